alu_sequencer: RTL
==================

# alu_sequencer

Multi-cycle fetch/decode/execute/writeback controller that sequences the combinational ALU. It fetches 32-bit instruction words over a request/acknowledge port and splits them into ALU control fields. It owns the PC and the architectural NZCV flags register, drives an external 16x32 register file and runs load/store transfers over a data-memory handshake. The block sits between instruction memory, data memory, the register file and the ALU.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; leaves IDLE; ignored in any other state
- imem_req  out  1  instruction fetch request
- imem_addr  out  32  word address, equals pc
- imem_ack  in  1  fetch complete, imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- rf_raddr1 / rf_raddr2  out  4  read addresses (rn; rm, or rd for STR)
- rf_rdata1 / rf_rdata2  in  32  combinational read data
- rf_we  out  1  register write strobe
- rf_waddr  out  4  write address (rd)
- rf_wdata  out  32  write data
- alu_cond / alu_opcode  out  4  ALU cond and opcode fields
- alu_sbit  out  1  ALU S bit
- alu_srcontrol  out  3  ALU shift/rotate select
- alu_imvalue  out  16  ALU immediate
- alu_in1 / alu_in2  out  32  rf_rdata1 / rf_rdata2 passthrough
- alu_inflags  out  4  flags_q {N,Z,C,V}
- alu_result  in  32  ALU result
- alu_outflags  in  4  ALU flags {N,Z,C,V}
- dmem_req  out  1  data request
- dmem_we  out  1  1 = store
- dmem_addr / dmem_wdata  out  32  address (rn value) / store data (rd value)
- dmem_ack  in  1  transfer complete
- dmem_rdata  in  32  load data
- busy  out  1  state != IDLE
- halted  out  1  set by HALT, cleared by start
- illegal  out  1  sticky, set on undefined opcode

## Operation
- Instruction fields: [31:28] cond, [27:24] opcode, [23] sbit, [22:20] srcontrol, [19:16] rd, [15:12] rn, [11:8] rm, [15:0] imvalue (whole field always driven).
- Opcodes: 0000 ADD, 0001 SUB, 0010 MUL, 0011 OR, 0100 AND, 0101 XOR, 0110 MOVN, 0111 MOVREG, 1000 CMP, 1001 LDR, 1010 STR, 1110 HALT, 1111 NOP. 1011–1101 are undefined: set illegal, no side effects.
- cond_met, evaluated on flags_q: 0001 Z; 0010 !Z&(N==V); 0011 !Z&(N!=V); 0100 N==V; 0101 N!=V; 0110 !Z&C; 0111 !C; 1000 C; any other code is always true. HALT also obeys cond.
- FSM states: IDLE, FETCH, DECODE, EXECUTE, MEM, WB.
- IDLE: on start, go to FETCH and clear halted.
- FETCH: imem_req=1 until imem_ack. On the ack cycle, latch instr, pc<=pc+1 (wraps FFFF_FFFF->0), go to DECODE.
- DECODE: one cycle. Register addresses and ALU fields are driven from instr.
- EXECUTE: one cycle. If cond_met and (sbit or CMP), flags_q<=alu_outflags. Next state:
  - cond false, CMP, NOP or undefined: FETCH
  - ops 0000–0111: latch alu_result, go to WB
  - LDR/STR: MEM
  - HALT: IDLE with halted=1
- MEM: dmem_req=1 with dmem_addr, dmem_we and dmem_wdata held stable until dmem_ack. LDR latches dmem_rdata and goes to WB. STR goes to FETCH.
- WB: rf_we=1 for one cycle, rf_waddr=rd, rf_wdata=latched value, then FETCH.
- Acks arriving while the matching req is low are ignored.

## Timing
- Reset (asynchronous assert): state IDLE, pc=RESET_PC, instr=0, flags_q=0, halted=0, illegal=0. All req/we outputs 0. ALU field outputs are 0.
- Reset asserted mid-transfer drops req in the same cycle. No writeback occurs.
- Cycles per instruction with same-cycle ack:
  - ALU op with writeback: 4
  - CMP, NOP, cond-false, undefined: 3
  - LDR: 5
  - STR: 4
- Each wait cycle on an ack adds one cycle.
- flags_q updated in EXECUTE is visible to the next instruction's cond evaluation.
- rf_we is never asserted outside WB. dmem_req is never asserted outside MEM.

## Test plan
- Reset, start, ADD with r1=5, r2=7, rd=3, ack immediate -> imem_req rises in the cycle after start. rf_we pulses once with waddr=3, wdata=12, four cycles after fetch begins. pc=1.
- CMP with sbit=1, alu_outflags=0100; next instruction has cond=0001 (EQ) -> writeback occurs. Same sequence with flags 0000 -> no rf_we, 3 cycles.
- LDR with rn value 0x40; dmem_ack delayed 3 cycles -> dmem_req held 4 cycles at addr 0x40, dmem_we=0. rf_we carries dmem_rdata.
- STR -> dmem_we=1, dmem_wdata equals the rd value, no rf_we. Opcode 1100 -> illegal=1, pc advances.
- HALT -> busy=0, halted=1. start resumes fetch at the next pc. pc=FFFF_FFFF wraps to 0.
- Reset asserted during a MEM wait -> dmem_req=0 immediately, pc=RESET_PC, no register write.

Source files
------------

// File: rtl/alu_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback controller around an external ALU.
// Owns the PC and NZCV flags, drives the register file and the data-memory handshake.
module alu_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [3:0]  rf_raddr1,
   output logic [3:0]  rf_raddr2,
   input  logic [31:0] rf_rdata1,
   input  logic [31:0] rf_rdata2,
   output logic        rf_we,
   output logic [3:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic [3:0]  alu_cond,
   output logic [3:0]  alu_opcode,
   output logic        alu_sbit,
   output logic [2:0]  alu_srcontrol,
   output logic [15:0] alu_imvalue,
   output logic [31:0] alu_in1,
   output logic [31:0] alu_in2,
   output logic [3:0]  alu_inflags,
   input  logic [31:0] alu_result,
   input  logic [3:0]  alu_outflags,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        busy,
   output logic        halted,
   output logic        illegal
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      EXECUTE,
      MEM,
      WB
   } state_t;

   localparam logic [3:0] OP_CMP  = 4'h8;
   localparam logic [3:0] OP_LDR  = 4'h9;
   localparam logic [3:0] OP_STR  = 4'hA;
   localparam logic [3:0] OP_HALT = 4'hE;
   localparam logic [3:0] OP_NOP  = 4'hF;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] instr;
   logic [3:0]  flags_q;
   logic [31:0] wb_data;
   logic        imem_req_q;
   logic        dmem_req_q;
   logic        dmem_we_q;
   logic [31:0] dmem_addr_q;
   logic [31:0] dmem_wdata_q;
   logic        rf_we_q;
   logic        halted_q;
   logic        illegal_q;

   logic [3:0]  f_cond;
   logic [3:0]  f_op;
   logic [3:0]  f_rd;
   logic [3:0]  f_rn;
   logic [3:0]  f_rm;
   logic        cond_met;
   logic        is_undef;

   assign f_cond = instr[31:28];
   assign f_op   = instr[27:24];
   assign f_rd   = instr[19:16];
   assign f_rn   = instr[15:12];
   assign f_rm   = instr[11:8];

   assign is_undef = (f_op == 4'hB) || (f_op == 4'hC) || (f_op == 4'hD);

   // Condition codes are evaluated on the architectural flags, never on the ALU's live output.
   always_comb begin
      cond_met = 1'b1;
      case (f_cond)
         4'h1:    cond_met = flags_q[2];
         4'h2:    cond_met = !flags_q[2] && (flags_q[3] == flags_q[0]);
         4'h3:    cond_met = !flags_q[2] && (flags_q[3] != flags_q[0]);
         4'h4:    cond_met = (flags_q[3] == flags_q[0]);
         4'h5:    cond_met = (flags_q[3] != flags_q[0]);
         4'h6:    cond_met = !flags_q[2] && flags_q[1];
         4'h7:    cond_met = !flags_q[1];
         4'h8:    cond_met = flags_q[1];
         default: cond_met = 1'b1;
      endcase
   end

   // Strobes are registered and set on the transition into the state that owns them.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         pc           <= RESET_PC;
         instr        <= 32'h0;
         flags_q      <= 4'h0;
         wb_data      <= 32'h0;
         imem_req_q   <= 1'b0;
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= 32'h0;
         dmem_wdata_q <= 32'h0;
         rf_we_q      <= 1'b0;
         halted_q     <= 1'b0;
         illegal_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= FETCH;
                  halted_q   <= 1'b0;
                  imem_req_q <= 1'b1;
               end
            end
            FETCH: begin
               if (imem_ack) begin
                  instr      <= imem_rdata;
                  pc         <= pc + 32'd1;
                  imem_req_q <= 1'b0;
                  state      <= DECODE;
               end
            end
            DECODE: begin
               state <= EXECUTE;
            end
            EXECUTE: begin
               if (is_undef) begin
                  illegal_q <= 1'b1;
               end
               if (cond_met && !is_undef && (instr[23] || (f_op == OP_CMP))) begin
                  flags_q <= alu_outflags;
               end
               if (!cond_met || is_undef || (f_op == OP_CMP) || (f_op == OP_NOP)) begin
                  imem_req_q <= 1'b1;
                  state      <= FETCH;
               end else if (!f_op[3]) begin
                  wb_data <= alu_result;
                  rf_we_q <= 1'b1;
                  state   <= WB;
               end else if ((f_op == OP_LDR) || (f_op == OP_STR)) begin
                  dmem_req_q   <= 1'b1;
                  dmem_we_q    <= (f_op == OP_STR);
                  dmem_addr_q  <= rf_rdata1;
                  dmem_wdata_q <= rf_rdata2;
                  state        <= MEM;
               end else begin
                  halted_q <= (f_op == OP_HALT);
                  state    <= IDLE;
               end
            end
            MEM: begin
               if (dmem_ack) begin
                  dmem_req_q <= 1'b0;
                  dmem_we_q  <= 1'b0;
                  if (f_op == OP_LDR) begin
                     wb_data <= dmem_rdata;
                     rf_we_q <= 1'b1;
                     state   <= WB;
                  end else begin
                     imem_req_q <= 1'b1;
                     state      <= FETCH;
                  end
               end
            end
            WB: begin
               rf_we_q    <= 1'b0;
               imem_req_q <= 1'b1;
               state      <= FETCH;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign imem_req      = imem_req_q;
   assign imem_addr     = pc;
   assign rf_raddr1     = f_rn;
   assign rf_raddr2     = (f_op == OP_STR) ? f_rd : f_rm;
   assign rf_we         = rf_we_q;
   assign rf_waddr      = f_rd;
   assign rf_wdata      = wb_data;
   assign alu_cond      = f_cond;
   assign alu_opcode    = f_op;
   assign alu_sbit      = instr[23];
   assign alu_srcontrol = instr[22:20];
   assign alu_imvalue   = instr[15:0];
   assign alu_in1       = rf_rdata1;
   assign alu_in2       = rf_rdata2;
   assign alu_inflags   = flags_q;
   assign dmem_req      = dmem_req_q;
   assign dmem_we       = dmem_we_q;
   assign dmem_addr     = dmem_addr_q;
   assign dmem_wdata    = dmem_wdata_q;
   assign busy          = (state != IDLE);
   assign halted        = halted_q;
   assign illegal       = illegal_q;

endmodule
